conv2d_seq: RTL and testbench



---
 rtl/conv2d_pkg.sv | 22 ++
 rtl/conv2d_seq_if.sv | 13 +
 rtl/conv2d_mac.sv | 59 +++++
 rtl/conv2d_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_conv2d_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and elaboration-time helpers for the sequential 2-D convolution engine.
package conv2d_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StMac,
    StWrite,
    StDone
  } conv_state_e;

  // Output spatial size for one dimension.
  function automatic int out_dim(int in_dim, int kernel, int stride, int padding);
    return (in_dim + 2 * padding - kernel) / stride + 1;
  endfunction

  // $clog2 that never returns zero, so counters and selects keep at least one bit.
  function automatic int clog2_min1(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_seq_if.sv
// Streamed-result handshake between the convolution engine and its consumer.
interface conv2d_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/conv2d_mac.sv
// Multiply-accumulate datapath with optional ReLU and saturation to the element width.
module conv2d_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_bias_i,
  input  logic                  mac_en_i,
  input  logic                  tap_ok_i,
  input  logic                  relu_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam logic signed [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d, acc_q, relu_v;

  assign prod = $signed(a_i) * $signed(b_i);

  // Accumulator next state: bias preload, or add the tap product (padding taps add nothing).
  always_comb begin
    acc_d = acc_q;
    if (load_bias_i) begin
      acc_d = ACC_WIDTH'($signed(bias_i));
    end else if (mac_en_i && tap_ok_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ReLU first, then clamp into the signed element range.
  always_comb begin
    relu_v = (relu_i && (acc_q < 0)) ? '0 : acc_q;
    if (relu_v > SatMax) begin
      result_o = SatMax[DATA_WIDTH-1:0];
    end else if (relu_v < SatMin) begin
      result_o = SatMin[DATA_WIDTH-1:0];
    end else begin
      result_o = relu_v[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv2d_seq.sv
// Sequential NCHW 2-D convolution: one MAC tap per cycle, results streamed and stored.
module conv2d_seq
  import conv2d_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 3,
  parameter int OUT_CHANNELS = 4,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int ACC_WIDTH    = 2 * DATA_WIDTH + 8,
  localparam int OUT_H       = out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING),
  localparam int OUT_W       = out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING),
  localparam int OUT_ELEMS   = BATCH_SIZE * OUT_CHANNELS * OUT_H * OUT_W,
  localparam int IN_BITS     = BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH * DATA_WIDTH,
  localparam int W_BITS      = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH,
  localparam int B_BITS      = OUT_CHANNELS * DATA_WIDTH,
  localparam int O_BITS      = OUT_ELEMS * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              relu_en,
  input  logic [IN_BITS-1:0] input_tensor_flat,
  input  logic [W_BITS-1:0] weights_flat,
  input  logic [B_BITS-1:0] bias_flat,
  conv2d_seq_if.master      out_if,
  output logic [O_BITS-1:0] output_tensor_flat,
  output logic              busy,
  output logic              done
);

  localparam int IdxW  = clog2_min1(OUT_ELEMS);
  localparam int BW    = clog2_min1(BATCH_SIZE);
  localparam int OcW   = clog2_min1(OUT_CHANNELS);
  localparam int OyW   = clog2_min1(OUT_H);
  localparam int OxW   = clog2_min1(OUT_W);
  localparam int IcW   = clog2_min1(IN_CHANNELS);
  localparam int KW    = clog2_min1(KERNEL_SIZE);
  localparam int InSW  = clog2_min1(IN_BITS);
  localparam int WSW   = clog2_min1(W_BITS);
  localparam int BSW   = clog2_min1(B_BITS);
  localparam int OSW   = clog2_min1(O_BITS);

  conv_state_e           state_d, state_q;
  logic                  relu_d, relu_q;
  logic [BW-1:0]         b_d, b_q;
  logic [OcW-1:0]        oc_d, oc_q;
  logic [OyW-1:0]        oy_d, oy_q;
  logic [OxW-1:0]        ox_d, ox_q;
  logic [IdxW-1:0]       idx_d, idx_q;
  logic [IcW-1:0]        ic_d, ic_q;
  logic [KW-1:0]         ky_d, ky_q, kx_d, kx_q;
  logic [O_BITS-1:0]     out_d, out_q;

  int                    iy, ix, in_sel, w_sel;
  logic                  tap_ok, load_bias, mac_en, out_valid;
  logic [InSW-1:0]       in_lsb;
  logic [WSW-1:0]        w_lsb;
  logic [BSW-1:0]        b_lsb;
  logic [OSW-1:0]        o_lsb;
  logic [DATA_WIDTH-1:0] in_elem, w_elem, bias_elem, result;

  // Tap address generation; out-of-bounds taps point at element 0 and are masked.
  always_comb begin
    iy        = int'(oy_q) * STRIDE + int'(ky_q) - PADDING;
    ix        = int'(ox_q) * STRIDE + int'(kx_q) - PADDING;
    tap_ok    = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    in_sel    = tap_ok ? ((((int'(b_q) * IN_CHANNELS + int'(ic_q)) * IN_HEIGHT + iy) * IN_WIDTH)
                          + ix) : 0;
    w_sel     = ((int'(oc_q) * IN_CHANNELS + int'(ic_q)) * KERNEL_SIZE + int'(ky_q)) * KERNEL_SIZE
                + int'(kx_q);
    in_lsb    = InSW'(in_sel * DATA_WIDTH);
    w_lsb     = WSW'(w_sel * DATA_WIDTH);
    b_lsb     = BSW'(int'(oc_q) * DATA_WIDTH);
    o_lsb     = OSW'(int'(idx_q) * DATA_WIDTH);
    in_elem   = input_tensor_flat[in_lsb +: DATA_WIDTH];
    w_elem    = weights_flat[w_lsb +: DATA_WIDTH];
    bias_elem = bias_flat[b_lsb +: DATA_WIDTH];
  end

  // Control FSM next state, counter stepping and result write-back.
  always_comb begin
    state_d   = state_q;
    relu_d    = relu_q;
    b_d       = b_q;
    oc_d      = oc_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    idx_d     = idx_q;
    ic_d      = ic_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    out_d     = out_q;
    load_bias = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          relu_d  = relu_en;
          b_d     = '0;
          oc_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          idx_d   = '0;
          ic_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          state_d = StBias;
        end
      end
      StBias: begin
        busy      = 1'b1;
        load_bias = 1'b1;
        state_d   = StMac;
      end
      StMac: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (kx_q == KW'(KERNEL_SIZE - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(KERNEL_SIZE - 1)) begin
            ky_d = '0;
            if (ic_q == IcW'(IN_CHANNELS - 1)) begin
              ic_d    = '0;
              state_d = StWrite;
            end else begin
              ic_d = ic_q + IcW'(1);
            end
          end else begin
            ky_d = ky_q + KW'(1);
          end
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end
      StWrite: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_if.out_ready) begin
          out_d[o_lsb +: DATA_WIDTH] = result;
          if (idx_q == IdxW'(OUT_ELEMS - 1)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StBias;
            // Odometer over ox, oy, oc, b to follow NCHW order.
            if (ox_q == OxW'(OUT_W - 1)) begin
              ox_d = '0;
              if (oy_q == OyW'(OUT_H - 1)) begin
                oy_d = '0;
                if (oc_q == OcW'(OUT_CHANNELS - 1)) begin
                  oc_d = '0;
                  b_d  = b_q + BW'(1);
                end else begin
                  oc_d = oc_q + OcW'(1);
                end
              end else begin
                oy_d = oy_q + OyW'(1);
              end
            end else begin
              ox_d = ox_q + OxW'(1);
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and output tensor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      relu_q  <= 1'b0;
      b_q     <= '0;
      oc_q    <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      idx_q   <= '0;
      ic_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      relu_q  <= relu_d;
      b_q     <= b_d;
      oc_q    <= oc_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      idx_q   <= idx_d;
      ic_q    <= ic_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      out_q   <= out_d;
    end
  end

  conv2d_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_bias_i (load_bias),
    .mac_en_i    (mac_en),
    .tap_ok_i    (tap_ok),
    .relu_i      (relu_q),
    .bias_i      (bias_elem),
    .a_i         (in_elem),
    .b_i         (w_elem),
    .result_o    (result)
  );

  assign out_if.out_valid  = out_valid;
  // Data is forced to zero outside WRITE so reset and idle present a clean bus.
  assign out_if.out_data   = (state_q == StWrite) ? result : '0;
  assign out_if.out_idx    = idx_q;
  assign output_tensor_flat = out_q;

endmodule

// File: tb/tb_conv2d_seq.sv
// Directed bench for conv2d_seq: vector table of full convolutions plus stall/reset/stride cases.
module tb_conv2d_seq;

  localparam int DW      = 32;
  localparam int IC      = 3;
  localparam int OC      = 4;
  localparam int H       = 8;
  localparam int W       = 8;
  localparam int K       = 3;
  localparam int NE      = 256;
  localparam int NE2     = 36;
  localparam int IN_BITS = IC * H * W * DW;
  localparam int W_BITS  = OC * IC * K * K * DW;
  localparam int B_BITS  = OC * DW;
  localparam int CYC     = IC * K * K + 2;

  logic                clk = 1'b0;
  logic                rst_n, start, start2, relu_en;
  logic [IN_BITS-1:0]  in_flat;
  logic [W_BITS-1:0]   w_flat;
  logic [B_BITS-1:0]   b_flat;
  logic [NE*DW-1:0]    out_flat;
  logic [NE2*DW-1:0]   out_flat2;
  logic                busy, done, busy2, done2;

  conv2d_seq_if #(.DATA_WIDTH(DW), .IDX_WIDTH(8)) o_if ();
  conv2d_seq_if #(.DATA_WIDTH(DW), .IDX_WIDTH(6)) o_if2 ();

  conv2d_seq dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .relu_en            (relu_en),
    .input_tensor_flat  (in_flat),
    .weights_flat       (w_flat),
    .bias_flat          (b_flat),
    .out_if             (o_if),
    .output_tensor_flat (out_flat),
    .busy               (busy),
    .done               (done)
  );

  conv2d_seq #(.STRIDE(2), .PADDING(0)) dut2 (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start2),
    .relu_en            (relu_en),
    .input_tensor_flat  (in_flat),
    .weights_flat       (w_flat),
    .bias_flat          (b_flat),
    .out_if             (o_if2),
    .output_tensor_flat (out_flat2),
    .busy               (busy2),
    .done               (done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in_v;
    logic [31:0] w_v;
    logic [31:0] b_v;
    logic        relu;
    logic [31:0] exp_c;
    logic [31:0] exp_e;
    logic [31:0] exp_i;
  } vec_t;

  vec_t        vecs[5];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cur_c, cur_e, cur_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected value by position class: corner (4 taps/ch), edge (6), interior (9).
  function automatic logic [31:0] exp_at(int idx);
    int ox = idx % W;
    int oy = (idx / W) % H;
    int nb = ((ox == 0 || ox == W - 1) ? 1 : 0) + ((oy == 0 || oy == H - 1) ? 1 : 0);
    return (nb == 2) ? cur_c : ((nb == 1) ? cur_e : cur_i);
  endfunction

  task automatic set_data(input logic [31:0] in_v, input logic [31:0] w_v,
                          input logic [31:0] b_v);
    for (int i = 0; i < IC * H * W; i++) in_flat[i*DW +: DW] = in_v;
    for (int i = 0; i < OC * IC * K * K; i++) w_flat[i*DW +: DW] = w_v;
    for (int i = 0; i < OC; i++) b_flat[i*DW +: DW] = b_v;
  endtask

  // One full convolution on dut; k counts edges after the start-sampling edge.
  task automatic run_main(input string tag, input logic relu, input int stall,
                          input int pulse_at, input int exp_done);
    int k = 0;
    int next_idx = 0;
    int stall_cnt = 0;
    int done_cyc = -1;
    @(negedge clk);
    relu_en = relu;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    while (done_cyc < 0 && k < 20000) begin
      @(negedge clk);
      k++;
      start = (k == pulse_at);
      if (k == 1) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      if (o_if.out_valid) begin
        if (o_if.out_idx == 8'd0 && stall_cnt < stall) begin
          o_if.out_ready = 1'b0;
          stall_cnt++;
          check({tag, "_stall_data"}, o_if.out_data, exp_at(0));
        end else begin
          o_if.out_ready = 1'b1;
          check({tag, "_idx"}, o_if.out_idx, next_idx);
          check({tag, "_stream"}, o_if.out_data, exp_at(next_idx));
          next_idx++;
        end
      end else begin
        o_if.out_ready = 1'b1;
      end
      if (done) begin
        done_cyc = k;
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_count"}, next_idx, NE);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    for (int i = 0; i < NE; i++) check({tag, "_tensor"}, out_flat[i*DW +: DW], exp_at(i));
  endtask

  initial begin
    int k;
    int n2;
    int done2_cyc;

    vecs[0] = '{32'h1, 32'h1, 32'h0, 1'b0, 32'd12, 32'd18, 32'd27};
    vecs[1] = '{32'h1, 32'h1, 32'hFFFF_FF9C, 1'b1, 32'd0, 32'd0, 32'd0};
    vecs[2] = '{32'h1, 32'h1, 32'hFFFF_FF9C, 1'b0, 32'hFFFF_FFA8, 32'hFFFF_FFAE, 32'hFFFF_FFB7};
    vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                32'h7FFF_FFFF};
    vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0001, 32'h0, 1'b0, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0000};

    rst_n           = 1'b0;
    start           = 1'b0;
    start2          = 1'b0;
    relu_en         = 1'b0;
    o_if.out_ready  = 1'b1;
    o_if2.out_ready = 1'b1;
    set_data(32'h1, 32'h1, 32'h0);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, o_if.out_valid}, 64'd0);
    check("rst_data", o_if.out_data, 64'd0);
    check("rst_idx", o_if.out_idx, 64'd0);
    check("rst_tensor_zero", {63'd0, out_flat == '0}, 64'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      set_data(vecs[v].in_v, vecs[v].w_v, vecs[v].b_v);
      cur_c = vecs[v].exp_c;
      cur_e = vecs[v].exp_e;
      cur_i = vecs[v].exp_i;
      run_main($sformatf("vec%0d", v), vecs[v].relu, 0, -1, NE * CYC);
    end

    // Back-pressure at idx 0 for five cycles, plus a start pulse while busy.
    set_data(32'h1, 32'h1, 32'h0);
    cur_c = 32'd12;
    cur_e = 32'd18;
    cur_i = 32'd27;
    run_main("stall", 1'b0, 5, 100, NE * CYC + 5);

    // Reset in the middle of the second element's MAC phase.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_elem0", out_flat[31:0], 64'd12);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_valid", {63'd0, o_if.out_valid}, 64'd0);
    check("mid_rst_data", o_if.out_data, 64'd0);
    check("mid_rst_idx", o_if.out_idx, 64'd0);
    check("mid_rst_tensor", {63'd0, out_flat == '0}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {63'd0, busy}, 64'd0);
    check("post_rst_done", {63'd0, done}, 64'd0);
    run_main("after_rst", 1'b0, 0, -1, NE * CYC);

    // Stride 2, no padding: 3x3 outputs per channel, all 27.
    @(negedge clk);
    relu_en = 1'b0;
    start2  = 1'b1;
    @(negedge clk);
    start2    = 1'b0;
    k         = 0;
    n2        = 0;
    done2_cyc = -1;
    while (done2_cyc < 0 && k < 5000) begin
      @(negedge clk);
      k++;
      if (o_if2.out_valid) begin
        check("s2_idx", o_if2.out_idx, n2);
        check("s2_stream", o_if2.out_data, 64'd27);
        n2++;
      end
      if (done2) done2_cyc = k;
    end
    check("s2_done_cycle", done2_cyc, NE2 * CYC);
    check("s2_count", n2, NE2);
    for (int i = 0; i < NE2; i++) check("s2_tensor", out_flat2[i*DW +: DW], 64'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
